demux4_dispatch_sched: RTL and testbench



---
 rtl/demux4_dispatch_sched_if.sv | 23 ++
 rtl/demux4_dispatch_sched.sv | 108 ++++++++++
 tb/tb_demux4_dispatch_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/demux4_dispatch_sched_if.sv
// Upstream word handshake, demux output lanes and per-lane credit return
// for the 4-lane dispatch scheduler.
interface demux4_dispatch_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [1:0]            sel;
    logic [DATA_WIDTH-1:0] out_data;
    logic [3:0]            out_valid;
    logic [3:0]            credit_ret;

    modport master (
        output in_valid, in_data, credit_ret,
        input  in_ready, sel, out_data, out_valid
    );

    modport slave (
        input  in_valid, in_data, credit_ret,
        output in_ready, sel, out_data, out_valid
    );
endinterface

// File: rtl/demux4_dispatch_sched.sv
// Round-robin 1:4 dispatch scheduler with per-lane credit tracking.
// Feeds one upstream stream to four PE input FIFOs without overrunning any of them.
module demux4_dispatch_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDITS    = 2,
    parameter int CW         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [3:0]                    lane_mask,
    demux4_dispatch_sched_if.slave        bus,
    output logic                          credit_err,
    output logic [2:0]                    busy_cnt
);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    logic [1:0]            rr_ptr;
    logic [3:0][CW-1:0]    credit_q;
    logic [3:0][CW-1:0]    credit_d;
    logic [3:0]            eligible;
    logic [1:0]            grant;
    logic [1:0]            idx;
    logic                  found;
    logic                  xfer;
    logic [3:0]            dispatch;
    logic                  ret_err;
    logic [2:0]            busy_d;
    logic [1:0]            sel_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            strobe_q;

    always_comb begin
        eligible = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = lane_mask[i] && (credit_q[i] != '0);
        end
    end

    // First eligible lane at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        grant = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign bus.in_ready = en && found;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign dispatch     = xfer ? (4'b0001 << grant) : 4'b0000;

    // A same-cycle dispatch and return cancel; a return on a full lane saturates and flags.
    always_comb begin
        credit_d = credit_q;
        ret_err  = 1'b0;
        busy_d   = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (dispatch[i] && !bus.credit_ret[i]) begin
                credit_d[i] = credit_q[i] - CW'(1);
            end else if (!dispatch[i] && bus.credit_ret[i]) begin
                if (credit_q[i] == CREDIT_MAX) begin
                    ret_err = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CW'(1);
                end
            end
            if (credit_d[i] == '0) begin
                busy_d = busy_d + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= 2'd0;
            credit_q   <= {4{CREDIT_MAX}};
            sel_q      <= 2'd0;
            data_q     <= '0;
            strobe_q   <= 4'b0000;
            credit_err <= 1'b0;
            busy_cnt   <= 3'd0;
        end else begin
            credit_q <= credit_d;
            busy_cnt <= busy_d;
            strobe_q <= dispatch;
            if (ret_err) begin
                credit_err <= 1'b1;
            end
            if (xfer) begin
                sel_q  <= grant;
                data_q <= bus.in_data;
                rr_ptr <= grant + 2'd1;
            end
        end
    end

    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = strobe_q;

endmodule

// File: tb/tb_demux4_dispatch_sched.sv
// Scoreboard bench for demux4_dispatch_sched: a lane/credit reference model predicts
// each cycle's outputs, and a negedge monitor compares whatever the DUT presents.
module tb_demux4_dispatch_sched;

    localparam int DW      = 8;
    localparam int CREDITS = 2;

    logic          clk;
    logic          reset;
    logic          en;
    logic [3:0]    lane_mask;
    logic          credit_err;
    logic [2:0]    busy_cnt;

    demux4_dispatch_sched_if #(.DATA_WIDTH(DW)) bus ();

    demux4_dispatch_sched #(.DATA_WIDTH(DW), .CREDITS(CREDITS), .CW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .lane_mask  (lane_mask),
        .bus        (bus.slave),
        .credit_err (credit_err),
        .busy_cnt   (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  ov;
        logic [1:0]  sel;
        logic [DW-1:0] data;
        logic [2:0]  busy;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;

    // Reference model state
    int          cred[4];
    int          rr;
    logic [1:0]  m_sel;
    logic [DW-1:0] m_data;
    logic        m_err;

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) cred[l] = CREDITS;
        rr     = 0;
        m_sel  = 2'd0;
        m_data = '0;
        m_err  = 1'b0;
    endtask

    // One cycle: apply inputs, check in_ready, advance model, push expected outputs.
    task automatic step(input bit e, input logic [3:0] m, input bit v,
                        input logic [DW-1:0] d, input logic [3:0] r);
        int   g;
        int   l;
        int   nb;
        bit   rdy;
        bit   xf;
        bit   dl;
        exp_t it;
        @(posedge clk);
        #2;
        en             = e;
        lane_mask      = m;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.credit_ret = r;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            l = (rr + k) % 4;
            if (g < 0 && m[l] && cred[l] > 0) g = l;
        end
        rdy = e && (g >= 0);
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        xf = v && rdy;
        for (int j = 0; j < 4; j++) begin
            dl = xf && (g == j);
            if (dl && !r[j]) cred[j] = cred[j] - 1;
            else if (!dl && r[j]) begin
                if (cred[j] == CREDITS) m_err = 1'b1;
                else cred[j] = cred[j] + 1;
            end
        end
        it.ov = 4'b0000;
        if (xf) begin
            it.ov     = 4'b0001 << g;
            m_sel     = 2'(g);
            m_data    = d;
            rr        = (g + 1) % 4;
        end
        nb = 0;
        for (int j = 0; j < 4; j++) if (cred[j] == 0) nb++;
        it.due  = edge_n + 1;
        it.sel  = m_sel;
        it.data = m_data;
        it.busy = 3'(nb);
        it.err  = m_err;
        q.push_back(it);
    endtask

    task automatic assert_reset();
        reset          = 1'b1;
        en             = 1'b0;
        lane_mask      = 4'h0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.credit_ret = 4'h0;
        q.delete();
        model_reset();
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sel",       32'(bus.sel),       32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_credit_err",32'(credit_err),    32'd0);
        check("rst_busy_cnt",  32'(busy_cnt),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        assert_reset();
        release_reset();
    endtask

    // Monitor: pops the expectation due at the edge just taken.
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].due == edge_n) begin
                exp_t it;
                it = q.pop_front();
                check("out_valid",  32'(bus.out_valid), 32'(it.ov));
                check("sel",        32'(bus.sel),       32'(it.sel));
                check("out_data",   32'(bus.out_data),  32'(it.data));
                check("busy_cnt",   32'(busy_cnt),      32'(it.busy));
                check("credit_err", 32'(credit_err),    32'(it.err));
            end else begin
                check("idle_out_valid", 32'(bus.out_valid), 32'd0);
            end
        end
    end

    initial begin
        logic [3:0] rr_ret;
        reset = 1'b1;
        assert_reset();
        release_reset();

        // Plain round robin across all lanes
        for (int i = 0; i < 5; i++) step(1, 4'hF, 1, 8'(10 + i), 4'h0);
        step(1, 4'hF, 0, 8'h00, 4'h0);

        // Credit exhaustion then a single return on lane 2
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 4'hF, 1, 8'(32 + i), 4'h0);
        step(1, 4'hF, 1, 8'h55, 4'b0100);
        step(1, 4'hF, 1, 8'h66, 4'h0);
        step(1, 4'hF, 1, 8'h77, 4'h0);

        // Masked lanes
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 4'b1010, 1, 8'(64 + i), 4'h0);
        step(1, 4'hF, 0, 8'h00, 4'h0);

        // Dispatch and return on the same lane in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 4'hF, 1, 8'(80 + i), 4'h0);
        step(1, 4'hF, 1, 8'hA0, 4'b0001);
        step(1, 4'hF, 0, 8'h00, 4'h0);

        // Return on a full lane is sticky error; credit saturates
        do_reset();
        step(0, 4'hF, 0, 8'h00, 4'b0001);
        for (int i = 0; i < 3; i++) step(1, 4'hF, 1, 8'(96 + i), 4'h0);
        step(1, 4'hF, 0, 8'h00, 4'h0);

        // Asynchronous reset while lane 2 is strobing
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 4'hF, 1, 8'(112 + i), 4'h0);
        @(posedge clk);
        #1;
        check("mid_pre_strobe", 32'(bus.out_valid), 32'b0100);
        #1;
        assert_reset();
        release_reset();
        step(1, 4'hF, 1, 8'hC3, 4'h0);
        step(1, 4'hF, 0, 8'h00, 4'h0);

        // Random traffic with returns only on lanes that have freed slots
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rr_ret = 4'h0;
            for (int l = 0; l < 4; l++)
                if (cred[l] < CREDITS && $urandom_range(2, 0) == 0) rr_ret[l] = 1'b1;
            step($urandom_range(9, 0) != 0, 4'($urandom), $urandom_range(3, 0) != 0,
                 8'($urandom), rr_ret);
        end

        // Fully random traffic including illegal returns
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(4, 0) != 0, 4'($urandom), 1'($urandom),
                 8'($urandom), 4'($urandom) & 4'($urandom));
        end
        step(1, 4'hF, 0, 8'h00, 4'h0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
